// File: rtl/mux_select_arbiter_4ch_if.sv
// Request/grant bundle between four sources and the 4:1 mux select arbiter.
// Optional feature macro: MUX_ARB_LOCK_EN adds the lock input.
interface mux_select_arbiter_4ch_if;
    logic [3:0] request;
    logic [1:0] select;
    logic [3:0] grant;
    logic       active;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;
`endif

    // Arbiter side: consumes requests, drives the mux select and grants.
    modport arb (
        input  request,
`ifdef MUX_ARB_LOCK_EN
        input  lock,
`endif
        output select,
        output grant,
        output active
    );

    // Requester side.
    modport master (
        output request,
`ifdef MUX_ARB_LOCK_EN
        output lock,
`endif
        input  select,
        input  grant,
        input  active
    );
endinterface

// File: rtl/mux_select_arbiter_4ch.sv
// Round-robin arbiter driving the select of a 24-bit 4:1 data mux.
// Each winner holds the path for up to BURST_LEN cycles, followed by a one-cycle
// bubble. All outputs are registered so select only moves at grant boundaries.
// Optional feature macro: MUX_ARB_LOCK_EN (lock suppresses the burst limit).
module mux_select_arbiter_4ch #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    mux_select_arbiter_4ch_if.arb    bus
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [CNT_W-1:0] CountMax = CNT_W'(BURST_LEN - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         last_sel_q, last_sel_d;
    logic [1:0]         select_q, select_d;
    logic [3:0]         grant_q, grant_d;
    logic               active_q, active_d;

    logic [1:0]         winner;
    logic [1:0]         cand;
    logic               found;
    logic               limit_hit;

    // Rotating-priority search starting just after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = 2'b00;
        cand   = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            cand = last_sel_q + 2'(k);
            if (!found && bus.request[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Burst limit reached; a held lock defers it until the request drops.
    always_comb begin
`ifdef MUX_ARB_LOCK_EN
        limit_hit = (count_q == CountMax) && !bus.lock;
`else
        limit_hit = (count_q == CountMax);
`endif
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        last_sel_d = last_sel_q;
        select_d   = select_q;
        grant_d    = grant_q;
        active_d   = active_q;
        unique case (state_q)
            StIdle: begin
                grant_d  = 4'b0000;
                active_d = 1'b0;
                if (found) begin
                    select_d   = winner;
                    grant_d    = 4'b0001 << winner;
                    active_d   = 1'b1;
                    count_d    = '0;
                    last_sel_d = winner;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (!bus.request[select_q] || limit_hit) begin
                    // Select is left alone so the mux output does not move on release.
                    grant_d  = 4'b0000;
                    active_d = 1'b0;
                    state_d  = StIdle;
                end else if (count_q != CountMax) begin
                    // Saturates here only while locked.
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; last_sel resets to 3 so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            last_sel_q <= 2'b11;
            select_q   <= 2'b00;
            grant_q    <= 4'b0000;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            last_sel_q <= last_sel_d;
            select_q   <= select_d;
            grant_q    <= grant_d;
            active_q   <= active_d;
        end
    end

    assign bus.select = select_q;
    assign bus.grant  = grant_q;
    assign bus.active = active_q;

endmodule
